// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive bit layer.
// Pure declarations: no latency, no flow control.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        WAIT_J = 2'd2
    } rx_state_t;

    localparam logic [7:0]  SYNC_PATTERN_DEF = 8'h80;
    localparam int unsigned STUFF_LEN_DEF    = 6;

endpackage

// File: rtl/nrzi_bit_decoder.sv
// NRZI decoder: remembers the previous line level and flags "no transition" as a decoded 1.
// dbit_o is combinational from line_bit_i; prev level advances only on strobes, clr_i forces idle J.
module nrzi_bit_decoder (
    input  logic clk,
    input  logic nRST,
    input  logic clr_i,
    input  logic strobe_i,
    input  logic line_bit_i,
    output logic dbit_o
);

    logic prev_line_q;
    logic prev_line_d;

    always_comb begin
        prev_line_d = prev_line_q;
        if (clr_i) begin
            prev_line_d = 1'b1;
        end else if (strobe_i) begin
            prev_line_d = line_bit_i;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            prev_line_q <= 1'b1;
        end else begin
            prev_line_q <= prev_line_d;
        end
    end

    assign dbit_o = (line_bit_i == prev_line_q);

endmodule

// File: rtl/usb_bit_receiver.sv
// USB receive bit layer: NRZI decode, SYNC hunt, destuffing, LSB-first byte assembly, EOP/stuff-error flags.
// All event outputs are registered one clk after the triggering bit_strobe; no backpressure, one bit per strobe.
module usb_bit_receiver
    import usb_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter int unsigned STUFF_LEN    = STUFF_LEN_DEF
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       en,
    input  logic       bit_strobe,
    input  logic       line_bit,
    input  logic       se0,
    output logic       rx_active,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       eop,
    output logic       eop_partial,
    output logic       stuff_err
);

    localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);

    rx_state_t  state_q,       state_d;
    logic [2:0] ones_cnt_q,    ones_cnt_d;
    logic [2:0] bit_cnt_q,     bit_cnt_d;
    logic [7:0] sync_sr_q,     sync_sr_d;
    logic [3:0] sync_cnt_q,    sync_cnt_d;
    logic [7:0] byte_sr_q,     byte_sr_d;
    logic       rx_active_q,   rx_active_d;
    logic [7:0] data_byte_q,   data_byte_d;
    logic       byte_valid_q,  byte_valid_d;
    logic       eop_q,         eop_d;
    logic       eop_partial_q, eop_partial_d;
    logic       stuff_err_q,   stuff_err_d;

    logic dbit;

    nrzi_bit_decoder u_nrzi (
        .clk        (clk),
        .nRST       (nRST),
        .clr_i      (!en),
        .strobe_i   (bit_strobe),
        .line_bit_i (line_bit),
        .dbit_o     (dbit)
    );

    always_comb begin
        state_d       = state_q;
        ones_cnt_d    = ones_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        sync_sr_d     = sync_sr_q;
        sync_cnt_d    = sync_cnt_q;
        byte_sr_d     = byte_sr_q;
        rx_active_d   = rx_active_q;
        data_byte_d   = data_byte_q;
        byte_valid_d  = 1'b0;
        eop_d         = 1'b0;
        eop_partial_d = 1'b0;
        stuff_err_d   = 1'b0;

        if (!en) begin
            state_d     = IDLE;
            ones_cnt_d  = 3'd0;
            bit_cnt_d   = 3'd0;
            sync_sr_d   = 8'h00;
            sync_cnt_d  = 4'd0;
            byte_sr_d   = 8'h00;
            rx_active_d = 1'b0;
        end else if (bit_strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (se0) begin
                        sync_sr_d  = 8'h00;
                        sync_cnt_d = 4'd0;
                    end else begin
                        sync_sr_d = {dbit, sync_sr_q[7:1]};
                        if (sync_cnt_q != 4'd8) begin
                            sync_cnt_d = sync_cnt_q + 4'd1;
                        end
                        // A cleared register plus one idle 1 aliases 8'h80, so demand a full byte of history.
                        if (sync_cnt_q >= 4'd7 && sync_sr_d == SYNC_PATTERN) begin
                            state_d     = DATA;
                            rx_active_d = 1'b1;
                            ones_cnt_d  = 3'd1;
                            bit_cnt_d   = 3'd0;
                            byte_sr_d   = 8'h00;
                        end
                    end
                end

                DATA: begin
                    if (se0) begin
                        eop_d         = 1'b1;
                        eop_partial_d = (bit_cnt_q != 3'd0);
                        rx_active_d   = 1'b0;
                        state_d       = WAIT_J;
                    end else if (ones_cnt_q == STUFF_CNT) begin
                        if (dbit) begin
                            stuff_err_d = 1'b1;
                            rx_active_d = 1'b0;
                            state_d     = WAIT_J;
                        end else begin
                            ones_cnt_d = 3'd0;
                        end
                    end else begin
                        byte_sr_d  = {dbit, byte_sr_q[7:1]};
                        ones_cnt_d = dbit ? (ones_cnt_q + 3'd1) : 3'd0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_byte_d  = byte_sr_d;
                            byte_valid_d = 1'b1;
                        end
                    end
                end

                WAIT_J: begin
                    if (!se0 && line_bit) begin
                        state_d    = IDLE;
                        sync_sr_d  = 8'h00;
                        sync_cnt_d = 4'd0;
                        ones_cnt_d = 3'd0;
                        bit_cnt_d  = 3'd0;
                        byte_sr_d  = 8'h00;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            ones_cnt_q    <= 3'd0;
            bit_cnt_q     <= 3'd0;
            sync_sr_q     <= 8'h00;
            sync_cnt_q    <= 4'd0;
            byte_sr_q     <= 8'h00;
            rx_active_q   <= 1'b0;
            data_byte_q   <= 8'h00;
            byte_valid_q  <= 1'b0;
            eop_q         <= 1'b0;
            eop_partial_q <= 1'b0;
            stuff_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ones_cnt_q    <= ones_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sync_sr_q     <= sync_sr_d;
            sync_cnt_q    <= sync_cnt_d;
            byte_sr_q     <= byte_sr_d;
            rx_active_q   <= rx_active_d;
            data_byte_q   <= data_byte_d;
            byte_valid_q  <= byte_valid_d;
            eop_q         <= eop_d;
            eop_partial_q <= eop_partial_d;
            stuff_err_q   <= stuff_err_d;
        end
    end

    assign rx_active   = rx_active_q;
    assign data_byte   = data_byte_q;
    assign byte_valid  = byte_valid_q;
    assign eop         = eop_q;
    assign eop_partial = eop_partial_q;
    assign stuff_err   = stuff_err_q;

endmodule

// File: tb/tb_usb_bit_receiver.sv
// Randomized bench: packets are built from byte lists, stuffed and NRZI-encoded here,
// and the expected byte/EOP/stuff-error events are queued for an independent monitor.
module tb_usb_bit_receiver;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       en = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       line_bit = 1'b1;
    logic       se0 = 1'b0;
    logic       rx_active;
    logic [7:0] data_byte;
    logic       byte_valid;
    logic       eop;
    logic       eop_partial;
    logic       stuff_err;

    always #5 clk = ~clk;

    usb_bit_receiver dut (
        .clk         (clk),
        .nRST        (nRST),
        .en          (en),
        .bit_strobe  (bit_strobe),
        .line_bit    (line_bit),
        .se0         (se0),
        .rx_active   (rx_active),
        .data_byte   (data_byte),
        .byte_valid  (byte_valid),
        .eop         (eop),
        .eop_partial (eop_partial),
        .stuff_err   (stuff_err)
    );

    typedef struct {
        int         kind;   // 0 byte, 1 eop, 2 stuff error
        logic [7:0] val;
        logic       part;
    } ev_t;
    typedef logic [7:0] bq_t[$];

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic       line_lvl = 1'b1;
    int         tx_ones = 0;
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the next queued expectation.
    always @(negedge clk) begin
        int  kind;
        int  npulse;
        ev_t e;
        if (nRST && (byte_valid || eop || stuff_err)) begin
            npulse = int'(byte_valid) + int'(eop) + int'(stuff_err);
            check("single_pulse", 32'(npulse), 32'd1);
            kind = byte_valid ? 0 : (eop ? 1 : 2);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got kind %0d, expected none", kind);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 32'(kind), 32'(e.kind));
                if (kind == 0) check("byte_value", 32'(data_byte), 32'(e.val));
                if (kind == 1) check("eop_partial", 32'(eop_partial), 32'(e.part));
            end
        end
    end

    task automatic strobe(input logic lvl, input logic s0);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bit_strobe = 1'b1;
        line_bit   = lvl;
        se0        = s0;
        @(posedge clk);
        #1;
        bit_strobe = 1'b0;
        se0        = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        if (!b) line_lvl = ~line_lvl;
        strobe(line_lvl, 1'b0);
    endtask

    task automatic idle_j(input int n);
        line_lvl = 1'b1;
        repeat (n) strobe(1'b1, 1'b0);
    endtask

    task automatic send_sync();
        repeat (7) send_bit(1'b0);
        check("rx_active_before_sync_end", 32'(rx_active), 32'd0);
        send_bit(1'b1);
        check("rx_active_after_sync", 32'(rx_active), 32'd1);
        tx_ones = 1;
    endtask

    task automatic send_dbit(input logic b);
        send_bit(b);
        tx_ones = b ? tx_ones + 1 : 0;
        if (tx_ones == 6) begin
            send_bit(1'b0);
            tx_ones = 0;
        end
    endtask

    task automatic send_packet(input bq_t data, input int extra);
        ev_t e;
        idle_j($urandom_range(1, 4));
        send_sync();
        foreach (data[i]) begin
            e = '{0, data[i], 1'b0};
            exp_q.push_back(e);
            last_byte = data[i];
            for (int j = 0; j < 8; j++) send_dbit(data[i][j]);
        end
        for (int j = 0; j < extra; j++) send_dbit(1'($urandom_range(0, 1)));
        e = '{1, 8'h00, (extra != 0)};
        exp_q.push_back(e);
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        line_lvl = 1'b1;
        strobe(1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t  pkt;
        ev_t  e;
        int   nb;
        int   ex;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_active", 32'(rx_active), 32'd0);
        check("reset_data_byte", 32'(data_byte), 32'h00);
        check("reset_pulses", 32'({byte_valid, eop, eop_partial, stuff_err}), 32'd0);
        nRST = 1'b1;
        en   = 1'b1;
        @(posedge clk);
        #1;

        idle_j(12);
        check("idle_rx_active", 32'(rx_active), 32'd0);
        check("idle_data_byte", 32'(data_byte), 32'h00);

        pkt = '{8'hA5};
        send_packet(pkt, 0);
        check("a5_data_byte", 32'(data_byte), 32'hA5);

        pkt = '{8'hFF};
        send_packet(pkt, 0);
        check("ff_data_byte", 32'(data_byte), 32'hFF);
        check("ff_rx_active_after_eop", 32'(rx_active), 32'd0);

        // Unstuffed run of 1s after SYNC must trip the stuff check.
        idle_j(3);
        send_sync();
        e = '{2, 8'h00, 1'b0};
        exp_q.push_back(e);
        repeat (7) send_bit(1'b1);
        check("stuff_err_rx_active", 32'(rx_active), 32'd0);
        idle_j(2);
        check("stuff_err_data_byte_held", 32'(data_byte), 32'hFF);

        pkt = {};
        send_packet(pkt, 3);

        repeat (8) begin
            pkt = {};
            nb  = $urandom_range(0, 3);
            for (int i = 0; i < nb; i++) pkt.push_back(8'($urandom_range(0, 255)));
            ex  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
            send_packet(pkt, ex);
        end

        // Enable dropped mid-byte.
        idle_j(2);
        send_sync();
        repeat (3) send_dbit(1'($urandom_range(0, 1)));
        check("en_mid_rx_active", 32'(rx_active), 32'd1);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_drop_rx_active", 32'(rx_active), 32'd0);
        check("en_drop_data_byte_held", 32'(data_byte), 32'(last_byte));
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;

        // Async reset mid-byte.
        idle_j(3);
        send_sync();
        repeat (4) send_dbit(1'($urandom_range(0, 1)));
        #2;
        nRST = 1'b0;
        #1;
        check("nrst_rx_active", 32'(rx_active), 32'd0);
        check("nrst_data_byte", 32'(data_byte), 32'h00);
        last_byte = 8'h00;
        @(posedge clk);
        #1;
        nRST = 1'b1;

        pkt = '{8'h3C};
        send_packet(pkt, 0);
        check("3c_data_byte", 32'(data_byte), 32'h3C);

        repeat (5) @(posedge clk);
        #1;
        check("events_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
